axis_burst_dma_writer: RTL and testbench
========================================

Name: axis_burst_dma_writer

Overview:
- Parametrised successor of the app-block stream sink: accepts an AXI-Stream of packet data and writes it into a memory ring through an AXI4 master write channel.
- Bursts are a fixed length, or shorter when TLAST closes a packet.
- Input is buffered in an internal FIFO. The write address wraps within a software-configured ring.
- Sits between the app-side stream source and the AXI interconnect to DDR/host memory.

Parameters:
DATA_WIDTH, 32, AXIS/AXI data width in bits (power of two, 32..512)
ADDR_WIDTH, 32, AXI address width
BURST_LEN, 16, maximum beats per AXI burst (power of two, 1..256; BURST_LEN*DATA_WIDTH/8 <= 4096)
FIFO_DEPTH, 64, input FIFO depth in beats (power of two, >= 2*BURST_LEN)
ID_WIDTH, 4, AWID width; AWID driven constant 0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_enable  in  1  1 = issue bursts; 0 = finish the current burst then idle
cfg_base  in  ADDR_WIDTH  ring base address (4 KiB aligned)
cfg_size  in  ADDR_WIDTH  ring size in bytes (multiple of 4 KiB, nonzero)
S_AXIS_TREADY  out  1  FIFO not full
S_AXIS_TDATA  in  DATA_WIDTH  stream data
S_AXIS_TSTRB  in  DATA_WIDTH/8  byte qualifier, forwarded as WSTRB
S_AXIS_TLAST  in  1  packet end
S_AXIS_TVALID  in  1  stream valid
S_AXIS_TUSER  in  1  frame start; counted only
M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWID  out  ADDR_WIDTH/8/3/2/ID_WIDTH  write address; AWBURST=INCR, AWSIZE=log2(DATA_WIDTH/8)
M_AXI_AWVALID  out  1 ; M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1 ; M_AXI_WREADY  in  1
M_AXI_BRESP  in  2 ; M_AXI_BVALID  in  1 ; M_AXI_BREADY  out  1
stat_bursts  out  32  completed bursts (B received)
stat_frames  out  32  accepted beats with TUSER=1
stat_err  out  1  sticky: any BRESP != OKAY
busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): all VALIDs, BREADY, busy and stat_* go to 0; FIFO is emptied; wr_ptr is loaded with cfg_base. Reset mid-burst abandons the burst with no further handshakes. The interconnect must be reset together with this block.
- FIFO stores {TDATA, TSTRB, TLAST}. S_AXIS_TREADY = !full, registered. A beat is accepted on TVALID&TREADY. A simultaneous push and pop when full is not allowed: TREADY is already 0. A push and pop when empty both take effect.
- tlast_cnt counts TLAST beats held in the FIFO: +1 on a push with TLAST, -1 on a pop with TLAST; both together leave it unchanged.
- Burst length: beats = BURST_LEN if fifo_count >= BURST_LEN, else (beats up to and including the first TLAST) if tlast_cnt > 0. A TLAST inside the first BURST_LEN beats always shortens the burst to end on it.
- FSM states:
  - IDLE: go to ADDR when cfg_enable and a burst is eligible. Latch len = beats-1 and AWADDR = wr_ptr.
  - ADDR: hold AWVALID until AWREADY, then go to DATA.
  - DATA: WVALID = 1 while in state (the FIFO is guaranteed non-empty). Pop on WREADY. WLAST on beat len. On the last handshake go to RESP. WLAST is generated from the beat counter; the stored TLAST is used only for counting.
  - RESP: BREADY = 1. On BVALID: stat_bursts++, stat_err |= (BRESP != 0), update wr_ptr, return to IDLE.
- AW and W are strictly serialised; there is no W-before-AW and one outstanding burst only.
- wr_ptr update:
  - full burst: wr_ptr += BURST_LEN*BYTES.
  - TLAST-terminated short burst: wr_ptr rounds up to the next BURST_LEN*BYTES boundary, so packets start aligned and no burst crosses 4 KiB.
  - If the result >= cfg_base+cfg_size, wr_ptr = cfg_base.
- cfg_base and cfg_size are sampled only in IDLE. A change takes effect on the next burst; wr_ptr is reloaded from cfg_base only by reset.
- stat counters wrap modulo 2^32. IDLE to AWVALID latency is 1 cycle.

Decomposition:
- Package axis_dma_pkg: the AXI BURST_INCR and RESP_OKAY constants, the FSM state enum, and a clog2-based AWSIZE helper.
- One sub-module, sync_fifo_fwft (first-word fall-through, width and depth parameters, count output), reused from the common library if it is already present.

Test Plan:
1. Defaults; 160 beats, data 1..160, no TLAST, AWREADY=WREADY=1 -> 10 bursts, AWLEN=15, AWADDR=base+0x40*n, WDATA in order, stat_bursts=10.
2. 5-beat packet with TLAST on beat 5 -> one burst AWLEN=4 at base; next packet AWADDR=base+0x40.
3. cfg_size=0x1000, 70 full bursts -> burst 64 at base+0xFC0, burst 65 at base (wrap).
4. Random AWREADY/WREADY/BVALID stalls at 50% with a continuous stream -> no data loss or reordering; TREADY drops when the FIFO holds 64 beats.
5. BRESP=2'b10 on the 3rd burst -> stat_err=1 and stays 1; stat_bursts continues to count.
6. rst_n low during DATA beat 7 -> next cycle all VALIDs are 0, FIFO is empty, stat=0; after release the first AWADDR=cfg_base.

Source files
------------

// File: rtl/axis_dma_pkg.sv
// Shared constants, FSM state type and helpers for the AXI-Stream burst DMA writer.
package axis_dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } dma_state_e;

  // AxSIZE encoding for a bus of the given byte width.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is visible on rdata whenever count is nonzero; when empty, a simultaneous
// push and pop pass the written word straight through.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (!empty || do_push);
  assign rdata   = empty ? wdata : mem[rd_ptr_q];
  assign count   = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axis_burst_dma_writer.sv
// AXI-Stream to AXI4 write-burst DMA into a software-configured memory ring.
// Beats are buffered in a FWFT FIFO; bursts are BURST_LEN beats, or shorter when a TLAST
// closes a packet. AW, W and B are strictly serialised with a single outstanding burst.
module axis_burst_dma_writer
  import axis_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_size,
  output logic                    S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TUSER,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [31:0]             stat_bursts,
  output logic [31:0]             stat_frames,
  output logic                    stat_err,
  output logic                    busy
);

  localparam int unsigned BYTES       = DATA_WIDTH / 8;
  localparam int unsigned SIZE_SHIFT  = $clog2(BYTES);
  localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = PW + 1;
  localparam int unsigned FW          = DATA_WIDTH + BYTES + 1;

  dma_state_e state_q, state_d;

  logic [FW-1:0]         fifo_rdata;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic                  tready_q;
  logic                  push;
  logic                  pop;
  logic                  push_last;
  logic                  pop_last;

  // Shadow copy of the TLAST bits so the next packet end can be located ahead of the head.
  logic                  last_mem [FIFO_DEPTH];
  logic [PW-1:0]         lw_idx_q;
  logic [PW-1:0]         lr_idx_q;
  logic [CW-1:0]         tlast_cnt_q;

  logic                  last_found;
  logic [7:0]            first_last;
  logic [7:0]            burst_len_m1;
  logic                  eligible;

  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] size_q;
  logic [31:0]           stat_bursts_q;
  logic [31:0]           stat_frames_q;
  logic                  stat_err_q;

  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [ADDR_WIDTH-1:0] rounded;
  logic [ADDR_WIDTH-1:0] ring_end;
  logic [ADDR_WIDTH-1:0] wr_ptr_next;

  assign push       = S_AXIS_TVALID && tready_q;
  assign pop        = (state_q == StData) && M_AXI_WREADY;
  assign push_last  = push && S_AXIS_TLAST;
  assign pop_last   = pop && fifo_rdata[0];
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Ready reflects the occupancy the FIFO will have after this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // TLAST shadow storage, written alongside the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      last_mem[lw_idx_q] <= S_AXIS_TLAST;
    end
  end

  // Shadow pointers and count of packet ends currently buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lw_idx_q    <= '0;
      lr_idx_q    <= '0;
      tlast_cnt_q <= '0;
    end else begin
      if (push) begin
        lw_idx_q <= lw_idx_q + PW'(1);
      end
      if (pop) begin
        lr_idx_q <= lr_idx_q + PW'(1);
      end
      tlast_cnt_q <= tlast_cnt_q + CW'(push_last) - CW'(pop_last);
    end
  end

  // Find the first buffered TLAST within the next BURST_LEN beats and size the burst.
  always_comb begin
    last_found = 1'b0;
    first_last = '0;
    for (int unsigned i = 0; i < BURST_LEN; i++) begin
      if (!last_found && (CW'(i) < fifo_count) && last_mem[lr_idx_q + PW'(i)]) begin
        last_found = 1'b1;
        first_last = 8'(i);
      end
    end
    burst_len_m1 = last_found ? first_last : 8'(BURST_LEN - 1);
    eligible     = (fifo_count >= CW'(BURST_LEN)) || (tlast_cnt_q != '0);
  end

  // Next ring pointer: advance to the next burst-aligned slot, wrapping at the ring end.
  always_comb begin
    burst_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SIZE_SHIFT;
    end_addr    = wr_ptr_q + burst_bytes;
    rounded     = (end_addr + ADDR_WIDTH'(BURST_BYTES - 1)) & ~ADDR_WIDTH'(BURST_BYTES - 1);
    ring_end    = base_q + size_q;
    wr_ptr_next = (rounded >= ring_end) ? base_q : rounded;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and channel handshake outputs.
  always_comb begin
    state_d       = state_q;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_enable && eligible) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) begin
          state_d = StData;
        end
      end
      StData: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = (beat_q == len_q);
        if (M_AXI_WREADY && (beat_q == len_q)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Burst bookkeeping, ring pointer and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q         <= '0;
      beat_q        <= '0;
      awaddr_q      <= '0;
      wr_ptr_q      <= cfg_base;
      base_q        <= cfg_base;
      size_q        <= cfg_size;
      stat_bursts_q <= '0;
      stat_frames_q <= '0;
      stat_err_q    <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        base_q <= cfg_base;
        size_q <= cfg_size;
        if (state_d == StAddr) begin
          len_q    <= burst_len_m1;
          awaddr_q <= wr_ptr_q;
        end
      end
      if ((state_q == StAddr) && M_AXI_AWREADY) begin
        beat_q <= '0;
      end else if (pop) begin
        beat_q <= beat_q + 8'd1;
      end
      if ((state_q == StResp) && M_AXI_BVALID) begin
        stat_bursts_q <= stat_bursts_q + 32'd1;
        stat_err_q    <= stat_err_q | (M_AXI_BRESP != RESP_OKAY);
        wr_ptr_q      <= wr_ptr_next;
      end
      if (push && S_AXIS_TUSER) begin
        stat_frames_q <= stat_frames_q + 32'd1;
      end
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = axi_size(BYTES);
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWID    = '0;
  assign M_AXI_WDATA   = fifo_rdata[FW-1 -: DATA_WIDTH];
  assign M_AXI_WSTRB   = fifo_rdata[BYTES:1];
  assign stat_bursts   = stat_bursts_q;
  assign stat_frames   = stat_frames_q;
  assign stat_err      = stat_err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_axis_burst_dma_writer.sv
// Directed bench for axis_burst_dma_writer: a stream source and an AXI write slave run in
// the background and log handshakes; each test task drives stimulus and checks the logs.
module tb_axis_burst_dma_writer;

  localparam logic [31:0] BASE = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_enable;
  logic [31:0] cfg_base;
  logic [31:0] cfg_size;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tvalid;
  logic        tuser;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] stat_bursts;
  logic [31:0] stat_frames;
  logic        stat_err;
  logic        busy;

  axis_burst_dma_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_base      (cfg_base),
    .cfg_size      (cfg_size),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TUSER  (tuser),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWID    (awid),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .stat_bursts   (stat_bursts),
    .stat_frames   (stat_frames),
    .stat_err      (stat_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t       src_q[$];
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  logic        w_last_q[$];
  int          b_cnt, pend_b, acc_cnt, pop_cnt, max_occ, blk_cnt, blk_bad, err_burst;
  bit          stall, b_keep;

  // Stream source and AXI write slave: drive on the falling edge, log handshakes 1 ns later.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    tvalid = 0; tdata = 0; tstrb = 0; tlast = 0; tuser = 0;
    forever begin
      @(negedge clk);
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_keep) bvalid = 1'b1;
      else bvalid = (pend_b > 0) && (!stall || ($urandom_range(0, 1) == 1));
      bresp = (b_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
      if (src_q.size() > 0) begin
        tvalid = 1'b1;
        tdata  = src_q[0].data;
        tstrb  = src_q[0].data[3:0];
        tlast  = src_q[0].last;
        tuser  = src_q[0].user;
      end else begin
        tvalid = 0; tdata = 0; tstrb = 0; tlast = 0; tuser = 0;
      end
      #1;
      if (!tready && (acc_cnt - pop_cnt) > 0) begin
        blk_cnt++;
        if (acc_cnt - pop_cnt != 64) blk_bad++;
      end
      if (acc_cnt - pop_cnt > max_occ) max_occ = acc_cnt - pop_cnt;
      if (tvalid && tready) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
      end
      if (wvalid && wready) begin
        w_data_q.push_back(wdata);
        w_strb_q.push_back(wstrb);
        w_last_q.push_back(wlast);
        pop_cnt++;
        if (wlast) pend_b++;
      end
      if (bvalid && bready) begin
        b_cnt++;
        pend_b--;
      end
      b_keep = bvalid && !bready;
    end
  end

  task automatic clear_records();
    src_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    b_cnt = 0; pend_b = 0; acc_cnt = 0; pop_cnt = 0; max_occ = 0;
    blk_cnt = 0; blk_bad = 0; b_keep = 0;
  endtask

  task automatic do_reset(input logic [31:0] base, input logic [31:0] size);
    cfg_base = base; cfg_size = size; cfg_enable = 1'b1;
    stall = 0; err_burst = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    clear_records();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n, input bit last_end,
                          input bit user_first);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = start + 32'(i);
      b.last = last_end && (i == n - 1);
      b.user = user_first && (i == 0);
      src_q.push_back(b);
    end
  endtask

  task automatic wait_bursts(input int n, input int limit, input string tag);
    for (int c = 0; c < limit && b_cnt < n; c++) @(posedge clk);
    if (b_cnt < n) begin
      $display("FAIL %s timeout: got %0d bursts, required %0d", tag, b_cnt, n);
      n_bad++;
    end
    n_cmp++;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    do_reset(BASE, 32'h0001_0000);
    if (awvalid !== 1'b0) begin $display("FAIL rst_awvalid got %b req 0", awvalid); n_bad++; end
    n_cmp++;
    if (wvalid !== 1'b0) begin $display("FAIL rst_wvalid got %b req 0", wvalid); n_bad++; end
    n_cmp++;
    if (bready !== 1'b0) begin $display("FAIL rst_bready got %b req 0", bready); n_bad++; end
    n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy got %b req 0", busy); n_bad++; end
    n_cmp++;
    if (stat_bursts !== 32'd0 || stat_frames !== 32'd0 || stat_err !== 1'b0) begin
      $display("FAIL rst_stats got %0d/%0d/%b req 0/0/0", stat_bursts, stat_frames, stat_err);
      n_bad++;
    end
    n_cmp++;
    if (tready !== 1'b1) begin $display("FAIL rst_tready got %b req 1", tready); n_bad++; end
    n_cmp++;
    if (awsize !== 3'd2 || awburst !== 2'b01 || awid !== 4'd0) begin
      $display("FAIL aw_const got size %0d burst %0d id %0d req 2/1/0", awsize, awburst, awid);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_enable();
    do_reset(BASE, 32'h0001_0000);
    cfg_enable = 1'b0;
    push_seq(32'h0000_0900, 16, 0, 0);
    repeat (40) @(posedge clk);
    #2;
    if (aw_addr_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL disabled_idle got %0d bursts busy %b req 0/0", aw_addr_q.size(), busy);
      n_bad++;
    end
    n_cmp++;
    cfg_enable = 1'b1;
    wait_bursts(1, 200, "enable");
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== BASE) begin
      $display("FAIL enable_burst got %0d bursts addr %h req 1 @ %h", aw_addr_q.size(),
               (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx, BASE);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_full_bursts();
    logic [31:0] v;
    do_reset(BASE, 32'h0001_0000);
    push_seq(32'd1, 160, 0, 0);
    wait_bursts(10, 4000, "full");
    if (aw_addr_q.size() != 10) begin
      $display("FAIL full_aw_count got %0d req 10", aw_addr_q.size()); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < aw_addr_q.size() && i < 10; i++) begin
      if (aw_addr_q[i] !== BASE + 32'(i * 'h40) || aw_len_q[i] !== 8'd15) begin
        $display("FAIL full_aw[%0d] got %h/%0d req %h/15", i, aw_addr_q[i], aw_len_q[i],
                 BASE + 32'(i * 'h40));
        n_bad++;
      end
      n_cmp++;
    end
    if (w_data_q.size() != 160) begin
      $display("FAIL full_w_count got %0d req 160", w_data_q.size()); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < w_data_q.size() && i < 160; i++) begin
      v = 32'(i + 1);
      if (w_data_q[i] !== v || w_strb_q[i] !== v[3:0] || w_last_q[i] !== ((i % 16) == 15)) begin
        $display("FAIL full_w[%0d] got %h/%h/%b req %h/%h/%b", i, w_data_q[i], w_strb_q[i],
                 w_last_q[i], v, v[3:0], (i % 16) == 15);
        n_bad++;
      end
      n_cmp++;
    end
    if (stat_bursts !== 32'd10) begin
      $display("FAIL full_stat_bursts got %0d req 10", stat_bursts); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_short_packets();
    logic [31:0] exp_addr[4];
    logic [7:0]  exp_len[4];
    int          last_idx[4];
    exp_addr = '{BASE, BASE + 32'h40, BASE + 32'h80, BASE + 32'hC0};
    exp_len  = '{8'd4, 8'd4, 8'd15, 8'd3};
    last_idx = '{4, 9, 25, 29};
    do_reset(BASE, 32'h0001_0000);
    push_seq(32'h0000_0A00, 5, 1, 1);
    push_seq(32'h0000_0B00, 5, 1, 1);
    push_seq(32'h0000_0C00, 20, 1, 1);
    wait_bursts(4, 1000, "short");
    for (int i = 0; i < 4 && i < aw_addr_q.size(); i++) begin
      if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== exp_len[i]) begin
        $display("FAIL short_aw[%0d] got %h/%0d req %h/%0d", i, aw_addr_q[i], aw_len_q[i],
                 exp_addr[i], exp_len[i]);
        n_bad++;
      end
      n_cmp++;
    end
    if (w_data_q.size() != 30) begin
      $display("FAIL short_w_count got %0d req 30", w_data_q.size()); n_bad++;
    end
    n_cmp++;
    for (int k = 0; k < 4 && last_idx[k] < w_data_q.size(); k++) begin
      if (w_last_q[last_idx[k]] !== 1'b1) begin
        $display("FAIL short_wlast[%0d] got %b req 1", last_idx[k], w_last_q[last_idx[k]]);
        n_bad++;
      end
      n_cmp++;
    end
    if (w_data_q.size() == 30 && (w_data_q[5] !== 32'h0B00 || w_data_q[29] !== 32'h0C13)) begin
      $display("FAIL short_order got %h/%h req 00000b00/00000c13", w_data_q[5], w_data_q[29]);
      n_bad++;
    end
    n_cmp++;
    if (stat_frames !== 32'd3) begin
      $display("FAIL short_frames got %0d req 3", stat_frames); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    int data_err = 0;
    do_reset(BASE, 32'h0000_1000);
    push_seq(32'h0010_0000, 70 * 16, 0, 0);
    wait_bursts(70, 6000, "wrap");
    if (aw_addr_q.size() == 70) begin
      if (aw_addr_q[63] !== BASE + 32'hFC0) begin
        $display("FAIL wrap_b64 got %h req %h", aw_addr_q[63], BASE + 32'hFC0); n_bad++;
      end
      n_cmp++;
      if (aw_addr_q[64] !== BASE) begin
        $display("FAIL wrap_b65 got %h req %h", aw_addr_q[64], BASE); n_bad++;
      end
      n_cmp++;
      if (aw_addr_q[69] !== BASE + 32'h140) begin
        $display("FAIL wrap_b70 got %h req %h", aw_addr_q[69], BASE + 32'h140); n_bad++;
      end
      n_cmp++;
    end else begin
      $display("FAIL wrap_aw_count got %0d req 70", aw_addr_q.size()); n_bad++; n_cmp++;
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'h0010_0000 + 32'(i)) data_err++;
    if (data_err != 0 || w_data_q.size() != 1120) begin
      $display("FAIL wrap_data got %0d beats %0d wrong req 1120/0", w_data_q.size(), data_err);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_stalls();
    int data_err = 0;
    do_reset(BASE, 32'h0001_0000);
    stall = 1;
    push_seq(32'h0020_0000, 320, 0, 0);
    wait_bursts(20, 8000, "stall");
    stall = 0;
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'h0020_0000 + 32'(i)) data_err++;
    if (data_err != 0 || w_data_q.size() != 320) begin
      $display("FAIL stall_data got %0d beats %0d wrong req 320/0", w_data_q.size(), data_err);
      n_bad++;
    end
    n_cmp++;
    if (max_occ != 64) begin
      $display("FAIL stall_max_occ got %0d req 64", max_occ); n_bad++;
    end
    n_cmp++;
    if (blk_cnt == 0 || blk_bad != 0) begin
      $display("FAIL stall_tready got %0d blocked cycles %0d not full req >0/0", blk_cnt, blk_bad);
      n_bad++;
    end
    n_cmp++;
    if (aw_len_q.size() == 20 && aw_addr_q[19] !== BASE + 32'h4C0) begin
      $display("FAIL stall_b20 got %h req %h", aw_addr_q[19], BASE + 32'h4C0); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_bresp_err();
    do_reset(BASE, 32'h0001_0000);
    err_burst = 3;
    push_seq(32'h0030_0000, 80, 0, 0);
    wait_bursts(2, 1000, "err_pre");
    if (stat_err !== 1'b0) begin
      $display("FAIL err_before got %b req 0", stat_err); n_bad++;
    end
    n_cmp++;
    wait_bursts(5, 2000, "err_post");
    if (stat_err !== 1'b1) begin
      $display("FAIL err_sticky got %b req 1", stat_err); n_bad++;
    end
    n_cmp++;
    if (stat_bursts !== 32'd5) begin
      $display("FAIL err_bursts got %0d req 5", stat_bursts); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_burst();
    int c;
    do_reset(BASE, 32'h0001_0000);
    push_seq(32'h0000_0100, 40, 0, 1);
    for (c = 0; c < 500 && w_data_q.size() < 7; c++) @(posedge clk);
    if (w_data_q.size() < 7) begin
      $display("FAIL mid_reach_beat7 got %0d beats req 7", w_data_q.size()); n_bad++;
    end
    n_cmp++;
    #2;
    cfg_base = 32'h0002_0000;
    rst_n = 1'b0;
    src_q.delete();
    @(posedge clk); #1;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mid_valids got aw %b w %b b %b busy %b req 0", awvalid, wvalid, bready,
               busy);
      n_bad++;
    end
    n_cmp++;
    if (stat_bursts !== 32'd0 || stat_frames !== 32'd0 || tready !== 1'b0) begin
      $display("FAIL mid_stats got %0d/%0d tready %b req 0/0/0", stat_bursts, stat_frames,
               tready);
      n_bad++;
    end
    n_cmp++;
    @(posedge clk); #2;
    clear_records();
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    if (aw_addr_q.size() != 0 || w_data_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL mid_fifo_empty got %0d aw %0d w busy %b req 0/0/0", aw_addr_q.size(),
               w_data_q.size(), busy);
      n_bad++;
    end
    n_cmp++;
    push_seq(32'h0000_5000, 16, 0, 0);
    wait_bursts(1, 500, "mid_after");
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h0002_0000) begin
      $display("FAIL mid_first_addr got %0d bursts addr %h req 1 @ 00020000", aw_addr_q.size(),
               (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx);
      n_bad++;
    end
    n_cmp++;
    if (w_data_q.size() != 16 || w_data_q[0] !== 32'h0000_5000) begin
      $display("FAIL mid_fresh_data got %0d beats first %h req 16 / 00005000", w_data_q.size(),
               (w_data_q.size() > 0) ? w_data_q[0] : 32'hx);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b1; cfg_base = BASE; cfg_size = 32'h0001_0000;
    stall = 0; err_burst = 0;
    clear_records();
    test_reset();
    test_enable();
    test_full_bursts();
    test_short_packets();
    test_wrap();
    test_stalls();
    test_bresp_err();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
